// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and sizing helpers for the window address sequencer
package router_pkg;

  typedef enum logic {IDLE, RUN} seq_state_e;
  typedef enum logic {MODE_DW, MODE_PW} conv_mode_e;

  localparam int DEF_MAX_KERNEL  = 3;
  localparam int DEF_ADDR_LENGTH = DEF_MAX_KERNEL * DEF_MAX_KERNEL;

  // Lanes needed to cover a square kernel of edge k.
  function automatic int lanes_for(input int k);
    return k * k;
  endfunction

endpackage

// File: rtl/window_addr_calc.sv
// rtl/window_addr_calc.sv - combinational per-lane read address and mask for one window
module window_addr_calc
  import router_pkg::*;
#(
  parameter int ADDR_WIDTH  = 6,
  parameter int MAX_KERNEL  = DEF_MAX_KERNEL,
  parameter int ADDR_LENGTH = lanes_for(MAX_KERNEL)
) (
  input  logic [ADDR_WIDTH-1:0]                   i_base_x,
  input  logic [ADDR_WIDTH-1:0]                   i_base_y,
  input  logic [ADDR_WIDTH-1:0]                   i_size,
  input  logic [ADDR_WIDTH-1:0]                   i_start_addr,
  input  logic                                    i_mode,
  output logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0]  o_addr,
  output logic [0:ADDR_LENGTH-1]                  o_mask
);

  // Lane (kx,ky) reads start + (base_x+kx)*size + base_y + ky; the sum wraps
  // naturally at ADDR_WIDTH bits. Pointwise windows only use lane 0.
  for (genvar kx = 0; kx < MAX_KERNEL; kx++) begin : g_kx
    for (genvar ky = 0; ky < MAX_KERNEL; ky++) begin : g_ky
      localparam int IDX = kx * MAX_KERNEL + ky;
      logic                  lane_en;
      logic [ADDR_WIDTH-1:0] lane_addr;

      assign lane_en     = (conv_mode_e'(i_mode) == MODE_DW) || (IDX == 0);
      assign lane_addr   = i_start_addr + (i_base_x + ADDR_WIDTH'(kx)) * i_size
                           + i_base_y + ADDR_WIDTH'(ky);
      assign o_addr[IDX] = lane_en ? lane_addr : '0;
      assign o_mask[IDX] = lane_en;
    end
  end

endmodule

// File: rtl/window_address_sequencer.sv
// rtl/window_address_sequencer.sv - scans one channel plane and emits one window of read addresses per beat
module window_address_sequencer
  import router_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int MAX_KERNEL  = DEF_MAX_KERNEL,
  parameter int ADDR_LENGTH = lanes_for(MAX_KERNEL),
  parameter int STRIDE_W    = 2
) (
  input  logic                                   i_clk,
  input  logic                                   i_nrst,
  input  logic                                   i_reg_clear,
  input  logic                                   i_start,
  input  logic                                   i_mode,
  input  logic [STRIDE_W-1:0]                    i_stride,
  input  logic [ADDR_WIDTH-1:0]                  i_i_size,
  input  logic [ADDR_WIDTH-1:0]                  i_start_addr,
  input  logic                                   i_ready,
  output logic                                   o_valid,
  output logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0] o_addr,
  output logic [0:ADDR_LENGTH-1]                 o_addr_mask,
  output logic [ADDR_WIDTH-1:0]                  o_o_x,
  output logic [ADDR_WIDTH-1:0]                  o_o_y,
  output logic [ROWS-1:0]                        o_row_id,
  output logic                                   o_busy,
  output logic                                   o_done
);

  localparam int CW = ADDR_WIDTH + 2;

  typedef logic [ADDR_WIDTH-1:0]                  aw_t;
  typedef logic [CW-1:0]                          cw_t;
  typedef logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0] addr_vec_t;

  seq_state_e            state_q, state_d;
  conv_mode_e            mode_q, mode_d;
  logic [STRIDE_W-1:0]   stride_q, stride_d;
  aw_t                   size_q, size_d;
  aw_t                   start_addr_q, start_addr_d;
  aw_t                   base_x_q, base_x_d;
  aw_t                   base_y_q, base_y_d;
  aw_t                   ptr_x_q, ptr_x_d;
  aw_t                   ptr_y_q, ptr_y_d;
  logic                  remain_q, remain_d;
  logic [ROWS-1:0]       row_ptr_q, row_ptr_d;
  logic                  valid_q, valid_d;
  addr_vec_t             addr_q, addr_d;
  logic [0:ADDR_LENGTH-1] mask_q, mask_d;
  aw_t                   out_x_q, out_x_d;
  aw_t                   out_y_q, out_y_d;
  logic [ROWS-1:0]       row_id_q, row_id_d;
  logic                  done_q, done_d;

  logic                  is_idle;
  conv_mode_e            cur_mode;
  logic [STRIDE_W-1:0]   cur_stride;
  aw_t                   cur_size, cur_start, cur_bx, cur_by, cur_ox, cur_oy;
  logic [ROWS-1:0]       cur_row;
  cw_t                   ke_w, step_w, size_w;
  logic                  can_y, can_x, has_first, load;
  addr_vec_t             calc_addr;
  logic [0:ADDR_LENGTH-1] calc_mask;

  // In IDLE the first window is built straight from the inputs so it is valid
  // the cycle after the start edge; in RUN the latched scan state is used.
  always_comb begin
    is_idle    = (state_q == IDLE);
    cur_mode   = is_idle ? conv_mode_e'(i_mode) : mode_q;
    cur_stride = is_idle ? ((i_stride == '0) ? STRIDE_W'(1) : i_stride) : stride_q;
    cur_size   = is_idle ? i_i_size     : size_q;
    cur_start  = is_idle ? i_start_addr : start_addr_q;
    cur_bx     = is_idle ? '0 : base_x_q;
    cur_by     = is_idle ? '0 : base_y_q;
    cur_ox     = is_idle ? '0 : ptr_x_q;
    cur_oy     = is_idle ? '0 : ptr_y_q;
    cur_row    = is_idle ? ROWS'(1) : row_ptr_q;
  end

  // Bound checks on widened operands so base+stride+kernel never wraps.
  always_comb begin
    ke_w      = (cur_mode == MODE_PW) ? cw_t'(1) : cw_t'(MAX_KERNEL);
    step_w    = cw_t'(cur_stride);
    size_w    = cw_t'(cur_size);
    can_y     = (cw_t'(cur_by) + step_w + ke_w) <= size_w;
    can_x     = (cw_t'(cur_bx) + step_w + ke_w) <= size_w;
    has_first = size_w >= ke_w;
  end

  window_addr_calc #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .MAX_KERNEL  (MAX_KERNEL),
    .ADDR_LENGTH (ADDR_LENGTH)
  ) u_calc (
    .i_base_x     (cur_bx),
    .i_base_y     (cur_by),
    .i_size       (cur_size),
    .i_start_addr (cur_start),
    .i_mode       (cur_mode),
    .o_addr       (calc_addr),
    .o_mask       (calc_mask)
  );

  // Next-state: FSM, output register load, scan pointer step, and clear override.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    stride_d     = stride_q;
    size_d       = size_q;
    start_addr_d = start_addr_q;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    ptr_x_d      = ptr_x_q;
    ptr_y_d      = ptr_y_q;
    remain_d     = remain_q;
    row_ptr_d    = row_ptr_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    mask_d       = mask_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    row_id_d     = row_id_q;
    done_d       = 1'b0;
    load         = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d      = RUN;
          mode_d       = cur_mode;
          stride_d     = cur_stride;
          size_d       = cur_size;
          start_addr_d = cur_start;
          base_x_d     = '0;
          base_y_d     = '0;
          ptr_x_d      = '0;
          ptr_y_d      = '0;
          row_ptr_d    = ROWS'(1);
          remain_d     = 1'b0;
          load         = has_first;
        end
      end
      RUN: begin
        if (!valid_q || i_ready) begin
          if (remain_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
    endcase

    // remain tracks whether the pointer now holds a window still to be emitted.
    if (load) begin
      valid_d   = 1'b1;
      addr_d    = calc_addr;
      mask_d    = calc_mask;
      out_x_d   = cur_ox;
      out_y_d   = cur_oy;
      row_id_d  = cur_row;
      row_ptr_d = {cur_row[ROWS-2:0], cur_row[ROWS-1]};
      remain_d  = can_y | can_x;
      if (can_y) begin
        base_y_d = cur_by + aw_t'(cur_stride);
        ptr_y_d  = cur_oy + aw_t'(1);
      end else if (can_x) begin
        base_y_d = '0;
        ptr_y_d  = '0;
        base_x_d = cur_bx + aw_t'(cur_stride);
        ptr_x_d  = cur_ox + aw_t'(1);
      end
    end

    if (i_reg_clear) begin
      state_d      = IDLE;
      mode_d       = MODE_DW;
      stride_d     = '0;
      size_d       = '0;
      start_addr_d = '0;
      base_x_d     = '0;
      base_y_d     = '0;
      ptr_x_d      = '0;
      ptr_y_d      = '0;
      remain_d     = 1'b0;
      row_ptr_d    = '0;
      valid_d      = 1'b0;
      addr_d       = '0;
      mask_d       = '0;
      out_x_d      = '0;
      out_y_d      = '0;
      row_id_d     = '0;
      done_d       = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= IDLE;
      mode_q       <= MODE_DW;
      stride_q     <= '0;
      size_q       <= '0;
      start_addr_q <= '0;
      base_x_q     <= '0;
      base_y_q     <= '0;
      ptr_x_q      <= '0;
      ptr_y_q      <= '0;
      remain_q     <= 1'b0;
      row_ptr_q    <= '0;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      mask_q       <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      row_id_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      stride_q     <= stride_d;
      size_q       <= size_d;
      start_addr_q <= start_addr_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      ptr_x_q      <= ptr_x_d;
      ptr_y_q      <= ptr_y_d;
      remain_q     <= remain_d;
      row_ptr_q    <= row_ptr_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      mask_q       <= mask_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      row_id_q     <= row_id_d;
      done_q       <= done_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_addr      = addr_q;
  assign o_addr_mask = mask_q;
  assign o_o_x       = out_x_q;
  assign o_o_y       = out_y_q;
  assign o_row_id    = row_id_q;
  assign o_busy      = (state_q == RUN);
  assign o_done      = done_q;

endmodule

// File: tb/tb_window_address_sequencer.sv
// tb/tb_window_address_sequencer.sv - self-checking bench for window_address_sequencer
module tb_window_address_sequencer;

  localparam int AW   = 6;
  localparam int K    = 3;
  localparam int AL   = 9;
  localparam int ROWS = 4;
  localparam int SW   = 2;

  logic                   clk = 1'b0;
  logic                   nrst = 1'b0;
  logic                   i_reg_clear = 1'b0;
  logic                   i_start = 1'b0;
  logic                   i_mode = 1'b0;
  logic [SW-1:0]          i_stride = '0;
  logic [AW-1:0]          i_i_size = '0;
  logic [AW-1:0]          i_start_addr = '0;
  logic                   i_ready = 1'b1;
  logic                   o_valid;
  logic [0:AL-1][AW-1:0]  o_addr;
  logic [0:AL-1]          o_addr_mask;
  logic [AW-1:0]          o_o_x, o_o_y;
  logic [ROWS-1:0]        o_row_id;
  logic                   o_busy, o_done;

  always #5 clk = ~clk;

  window_address_sequencer #(
    .ROWS(ROWS), .ADDR_WIDTH(AW), .MAX_KERNEL(K), .ADDR_LENGTH(AL), .STRIDE_W(SW)
  ) dut (
    .i_clk(clk), .i_nrst(nrst), .i_reg_clear(i_reg_clear), .i_start(i_start),
    .i_mode(i_mode), .i_stride(i_stride), .i_i_size(i_i_size), .i_start_addr(i_start_addr),
    .i_ready(i_ready), .o_valid(o_valid), .o_addr(o_addr), .o_addr_mask(o_addr_mask),
    .o_o_x(o_o_x), .o_o_y(o_o_y), .o_row_id(o_row_id), .o_busy(o_busy), .o_done(o_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [0:AL-1][AW-1:0] addr;
    logic [0:AL-1]         mask;
    logic [AW-1:0]         ox;
    logic [AW-1:0]         oy;
    logic [ROWS-1:0]       row;
  } win_t;

  win_t exp_q[$];
  int   exp_idx = 0;
  bit   sb_en = 1'b0;
  bit   last_acc = 1'b0;

  // Expected window list: n = (size-Ke)/S + 1 positions per edge, x outer, y inner.
  task automatic build_model(input bit mode, input int stride, input int size, input int start);
    int   s, ke, n, a;
    win_t w;
    exp_q.delete();
    s  = (stride == 0) ? 1 : stride;
    ke = mode ? 1 : K;
    n  = (size >= ke) ? (size - ke) / s + 1 : 0;
    for (int x = 0; x < n; x++) begin
      for (int y = 0; y < n; y++) begin
        w.ox  = AW'(x);
        w.oy  = AW'(y);
        w.row = '0;
        w.row[exp_q.size() % ROWS] = 1'b1;
        for (int kx = 0; kx < K; kx++) begin
          for (int ky = 0; ky < K; ky++) begin
            w.addr[kx*K+ky] = '0;
            w.mask[kx*K+ky] = 1'b0;
            if (!mode || (kx == 0 && ky == 0)) begin
              a = (start + (x*s + kx) * size + y*s + ky) % 64;
              w.addr[kx*K+ky] = AW'(a);
              w.mask[kx*K+ky] = 1'b1;
            end
          end
        end
        exp_q.push_back(w);
      end
    end
  endtask

  // Scoreboard: every valid cycle must show the next unconsumed window;
  // o_done must follow the last handshake by exactly one cycle.
  always @(negedge clk) begin : sb_cmp
    bit acc_now;
    if (sb_en) begin
      acc_now = 1'b0;
      if (exp_q.size() != 0) chk("sb_done", 64'(o_done), 64'(last_acc));
      if (o_valid) begin
        if (exp_idx >= exp_q.size()) begin
          checks++;
          failures++;
          $display("FAIL sb_extra_window index=%0d expected_total=%0d", exp_idx, exp_q.size());
        end else begin
          chk("sb_addr", 64'(o_addr), 64'(exp_q[exp_idx].addr));
          chk("sb_mask", 64'(o_addr_mask), 64'(exp_q[exp_idx].mask));
          chk("sb_ox", 64'(o_o_x), 64'(exp_q[exp_idx].ox));
          chk("sb_oy", 64'(o_o_y), 64'(exp_q[exp_idx].oy));
          chk("sb_row", 64'(o_row_id), 64'(exp_q[exp_idx].row));
          if (i_ready) begin
            exp_idx++;
            acc_now = (exp_idx == exp_q.size());
          end
        end
      end
      last_acc = acc_now;
    end
  end

  function automatic logic ready_pat(input int pat, input int cyc);
    case (pat)
      1:       return !(cyc >= 2 && cyc <= 4);
      2:       return 1'($urandom_range(0, 1));
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_scan(input bit mode, input int stride, input int size, input int start, input int pat);
    int cyc;
    bit got_done;
    build_model(mode, stride, size, start);
    @(posedge clk); #1;
    exp_idx      = 0;
    last_acc     = 1'b0;
    i_mode       = mode;
    i_stride     = SW'(stride);
    i_i_size     = AW'(size);
    i_start_addr = AW'(start);
    i_ready      = 1'b1;
    i_start      = 1'b1;
    sb_en        = 1'b1;
    @(posedge clk); #1;
    i_start      = 1'b0;
    i_mode       = ~mode;
    i_i_size     = '0;
    i_start_addr = '1;
    cyc      = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 300) begin
      @(negedge clk);
      if (cyc == 0) begin
        chk("first_valid", 64'(o_valid), 64'(exp_q.size() != 0));
        chk("busy_in_run", 64'(o_busy), 64'd1);
      end
      if (o_done) got_done = 1'b1;
      else begin
        @(posedge clk); #1;
        i_ready = ready_pat(pat, cyc);
        cyc++;
      end
    end
    if (!got_done) begin
      checks++;
      failures++;
      $display("FAIL scan_timeout cycles=%0d expected_done_within=300", cyc);
    end
    chk("window_count", 64'(exp_idx), 64'(exp_q.size()));
    if (pat == 0) chk("done_latency", 64'(cyc), 64'((exp_q.size() == 0) ? 1 : exp_q.size()));
    @(posedge clk); #1;
    i_ready = 1'b1;
    @(negedge clk);
    chk("done_one_cycle", 64'(o_done), 64'd0);
    chk("busy_after_done", 64'(o_busy), 64'd0);
    chk("valid_after_done", 64'(o_valid), 64'd0);
    sb_en = 1'b0;
  endtask

  logic [0:AL-1][AW-1:0] lit_w0;
  int                    wait_cyc;

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_addr", 64'(o_addr), 64'd0);
    chk("rst_row", 64'(o_row_id), 64'd0);
    chk("rst_busy_done", 64'({o_busy, o_done}), 64'd0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // DW 4x4, stride 1, base 0.
    run_scan(1'b0, 1, 4, 0, 0);
    lit_w0 = {6'd0, 6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9, 6'd10};
    chk("model_dw4_count", 64'(exp_q.size()), 64'd4);
    chk("model_dw4_w0", 64'(exp_q[0].addr), 64'(lit_w0));
    chk("model_dw4_row3", 64'(exp_q[3].row), 64'b1000);

    // DW 5x5, stride 2, base 3.
    run_scan(1'b0, 2, 5, 3, 0);
    chk("model_s2_lane0", 64'(exp_q[3].addr[0]), 64'd15);
    chk("model_s2_lane8", 64'(exp_q[3].addr[8]), 64'd27);

    // PW 3x3, stride 1.
    run_scan(1'b1, 1, 3, 0, 0);
    chk("model_pw_count", 64'(exp_q.size()), 64'd9);
    chk("model_pw_last", 64'(exp_q[8].addr[0]), 64'd8);
    chk("model_pw_row_wrap", 64'(exp_q[4].row), 64'b0001);

    // Backpressure: three stalled cycles mid-scan.
    run_scan(1'b0, 1, 5, 7, 1);

    // Random backpressure, stride 0 behaves as 1.
    run_scan(1'b0, 0, 6, 5, 2);
    chk("model_s0_count", 64'(exp_q.size()), 64'd16);

    // Address wrap modulo 64.
    run_scan(1'b0, 1, 4, 60, 0);
    chk("model_wrap_lane8", 64'(exp_q[0].addr[8]), 64'd6);

    // Degenerate plane smaller than kernel.
    run_scan(1'b0, 1, 2, 0, 0);
    chk("model_degen_count", 64'(exp_q.size()), 64'd0);

    // Clear in the middle of a scan, at window 2 = (1,0).
    @(posedge clk); #1;
    i_mode = 1'b0; i_stride = 2'd1; i_i_size = 6'd4; i_start_addr = 6'd0;
    i_ready = 1'b1; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_cyc = 0;
    do begin
      @(negedge clk);
      wait_cyc++;
    end while (!(o_valid && o_o_x == 6'd1 && o_o_y == 6'd0) && wait_cyc < 20);
    chk("clear_reached_w2", 64'(wait_cyc), 64'd3);
    i_reg_clear = 1'b1;
    @(negedge clk);
    chk("clear_valid", 64'(o_valid), 64'd0);
    chk("clear_busy", 64'(o_busy), 64'd0);
    chk("clear_done", 64'(o_done), 64'd0);
    chk("clear_row", 64'(o_row_id), 64'd0);
    i_reg_clear = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("clear_no_done", 64'({o_done, o_valid}), 64'd0);
    end

    // Re-start after clear begins at (0,0) with row 0001.
    run_scan(1'b0, 1, 4, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
